// File: rtl/cond_issue_ctrl.sv
// Conditional-execution controller: owns NZCV, evaluates ARM condition codes at issue,
// scoreboards in-flight flag writers and drives a registered pass/squash decision to execute.
module cond_issue_ctrl #(
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid_i,
    input  logic [3:0]       iss_cond_i,
    input  logic             iss_sets_fl_i,
    output logic             iss_ready_o,
    input  logic             ex_stall_i,
    output logic             ex_valid_o,
    output logic             ex_pass_o,
    input  logic             wb_fl_valid_i,
    input  logic [3:0]       wb_nzcv_i,
    input  logic             flush_i,
    output logic [3:0]       nzcv_o,
    output logic [CNT_W-1:0] squash_cnt_o,
    output logic             pend_err_o
);

    localparam int unsigned PW      = $clog2(MAX_PEND + 1);
    localparam logic [3:0]  COND_AL = 4'hE;
    localparam logic [3:0]  COND_NV = 4'hF;

    // ARM condition-code evaluation against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        logic res;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    res = z;
            4'h1:    res = !z;
            4'h2:    res = cf;
            4'h3:    res = !cf;
            4'h4:    res = n;
            4'h5:    res = !n;
            4'h6:    res = v;
            4'h7:    res = !v;
            4'h8:    res = cf && !z;
            4'h9:    res = !cf || z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = !z && (n == v);
            4'hD:    res = z || (n != v);
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [PW-1:0]    pend_q, pend_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             ex_valid_q, ex_valid_d;
    logic             ex_pass_q, ex_pass_d;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic             pend_err_q, pend_err_d;

    logic [3:0] fl_eval;
    logic       eval, flag_dep, hazard, capacity, ready, accept, inc, dec;

    // Issue decision: bypass the last outstanding writer's flags when it retires now
    always_comb begin
        fl_eval  = (wb_fl_valid_i && (pend_q == PW'(1))) ? wb_nzcv_i : nzcv_q;
        eval     = cond_pass(iss_cond_i, fl_eval);
        flag_dep = (iss_cond_i != COND_AL) && (iss_cond_i != COND_NV);
        hazard   = flag_dep && ((pend_q > PW'(1)) || ((pend_q == PW'(1)) && !wb_fl_valid_i));
        capacity = iss_sets_fl_i && (pend_q == PW'(MAX_PEND)) && !wb_fl_valid_i;
        ready    = !rst && !flush_i && !ex_stall_i && !hazard && !capacity;
        accept   = iss_valid_i && ready;
        inc      = accept && eval && iss_sets_fl_i;
        dec      = wb_fl_valid_i && (pend_q != '0);
    end

    always_comb begin
        pend_d     = pend_q;
        nzcv_d     = nzcv_q;
        ex_valid_d = ex_valid_q;
        ex_pass_d  = ex_pass_q;
        squash_d   = squash_q;
        pend_err_d = pend_err_q;

        if (wb_fl_valid_i) nzcv_d = wb_nzcv_i;
        if (wb_fl_valid_i && (pend_q == '0)) pend_err_d = 1'b1;

        if (flush_i) begin
            pend_d     = '0;
            ex_valid_d = 1'b0;
            ex_pass_d  = 1'b0;
        end else begin
            if (inc && !dec)      pend_d = pend_q + PW'(1);
            else if (dec && !inc) pend_d = pend_q - PW'(1);

            if (accept) begin
                ex_valid_d = 1'b1;
                ex_pass_d  = eval;
            end else if (!ex_stall_i) begin
                ex_valid_d = 1'b0;
                ex_pass_d  = 1'b0;
            end
        end

        if (accept && !eval && (squash_q != '1)) squash_d = squash_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            nzcv_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_pass_q  <= 1'b0;
            squash_q   <= '0;
            pend_err_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            nzcv_q     <= nzcv_d;
            ex_valid_q <= ex_valid_d;
            ex_pass_q  <= ex_pass_d;
            squash_q   <= squash_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign iss_ready_o  = ready;
    assign ex_valid_o   = ex_valid_q;
    assign ex_pass_o    = ex_pass_q;
    assign nzcv_o       = nzcv_q;
    assign squash_cnt_o = squash_q;
    assign pend_err_o   = pend_err_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Bench for cond_issue_ctrl: condition-code table with bypassed flags, plus hazard,
// capacity, stall/flush and underflow sequences; execute-slot results go through a scoreboard queue.
module tb_cond_issue_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             iss_valid, iss_sets_fl, iss_ready;
    logic [3:0]       iss_cond;
    logic             ex_stall, ex_valid, ex_pass;
    logic             wb_fl_valid, flush, pend_err;
    logic [3:0]       wb_nzcv, nzcv;
    logic [CNT_W-1:0] squash_cnt;

    cond_issue_ctrl #(.MAX_PEND(3), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid_i  (iss_valid),
        .iss_cond_i   (iss_cond),
        .iss_sets_fl_i(iss_sets_fl),
        .iss_ready_o  (iss_ready),
        .ex_stall_i   (ex_stall),
        .ex_valid_o   (ex_valid),
        .ex_pass_o    (ex_pass),
        .wb_fl_valid_i(wb_fl_valid),
        .wb_nzcv_i    (wb_nzcv),
        .flush_i      (flush),
        .nzcv_o       (nzcv),
        .squash_cnt_o (squash_cnt),
        .pend_err_o   (pend_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic p;
    } ex_exp_t;

    typedef struct packed {
        logic [3:0] cond;
        logic [3:0] fl;
        logic       exp;
    } vec_t;

    ex_exp_t sb_q[$];
    vec_t    tbl[21];
    int      total = 0;
    int      bad   = 0;
    int      exp_sq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One issue cycle: drive, check comb ready, push expected execute-slot result, then pop/compare it
    task automatic cyc(input logic v, input logic [3:0] c, input logic sfl, input logic stall,
                       input logic wbv, input logic [3:0] wbf, input logic fl,
                       input logic exp_rdy, input logic exp_v, input logic exp_p);
        ex_exp_t e;
        iss_valid = v; iss_cond = c; iss_sets_fl = sfl; ex_stall = stall;
        wb_fl_valid = wbv; wb_nzcv = wbf; flush = fl;
        #1;
        chk("iss_ready", 32'(iss_ready), 32'(exp_rdy));
        sb_q.push_back('{v: exp_v, p: exp_p});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(e.v));
            chk("ex_pass", 32'(ex_pass), 32'(e.p));
        end
        iss_valid = 1'b0; wb_fl_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        iss_sets_fl = 1'b0; iss_cond = 4'hE;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'h0, 4'b0100, 1'b1};
        tbl[1]  = '{4'h0, 4'b0000, 1'b0};
        tbl[2]  = '{4'h1, 4'b0000, 1'b1};
        tbl[3]  = '{4'h2, 4'b0010, 1'b1};
        tbl[4]  = '{4'h3, 4'b0010, 1'b0};
        tbl[5]  = '{4'h4, 4'b1000, 1'b1};
        tbl[6]  = '{4'h5, 4'b1000, 1'b0};
        tbl[7]  = '{4'h6, 4'b0001, 1'b1};
        tbl[8]  = '{4'h7, 4'b0000, 1'b1};
        tbl[9]  = '{4'h8, 4'b0010, 1'b1};
        tbl[10] = '{4'h8, 4'b0110, 1'b0};
        tbl[11] = '{4'h9, 4'b0110, 1'b1};
        tbl[12] = '{4'hA, 4'b1001, 1'b1};
        tbl[13] = '{4'hA, 4'b1000, 1'b0};
        tbl[14] = '{4'hB, 4'b1000, 1'b1};
        tbl[15] = '{4'hC, 4'b0000, 1'b1};
        tbl[16] = '{4'hC, 4'b0100, 1'b0};
        tbl[17] = '{4'hD, 4'b0100, 1'b1};
        tbl[18] = '{4'hD, 4'b0001, 1'b1};
        tbl[19] = '{4'hE, 4'b0000, 1'b1};
        tbl[20] = '{4'hF, 4'b1111, 1'b0};

        rst = 1'b1;
        iss_valid = 1'b1; iss_cond = 4'hE; iss_sets_fl = 1'b0; ex_stall = 1'b0;
        wb_fl_valid = 1'b1; wb_nzcv = 4'b1111; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(iss_ready), 32'd0);
        chk("rst_nzcv", 32'(nzcv), 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_pass", 32'(ex_pass), 32'd0);
        chk("rst_squash", 32'(squash_cnt), 32'd0);
        chk("rst_pend_err", 32'(pend_err), 32'd0);
        chk("rst_pend", 32'(dut.pend_q), 32'd0);
        rst = 1'b0; iss_valid = 1'b0; wb_fl_valid = 1'b0;

        // AL non-S op issues and passes
        cyc(1, 4'hE, 0, 0, 0, 4'h0, 0, 1, 1, 1);
        chk("t1_pend", 32'(dut.pend_q), 32'd0);

        // Condition table: S-op opens a writer, its writeback is bypassed into the next issue
        for (int i = 0; i < 21; i++) begin
            cyc(1, 4'hE, 1, 0, 0, 4'h0, 0, 1, 1, 1);
            cyc(1, tbl[i].cond, 0, 0, 1, tbl[i].fl, 0, 1, 1, tbl[i].exp);
            if (!tbl[i].exp) exp_sq++;
            chk($sformatf("tbl%0d_nzcv", i), 32'(nzcv), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d_pend", i), 32'(dut.pend_q), 32'd0);
            chk($sformatf("tbl%0d_squash", i), 32'(squash_cnt), 32'(exp_sq));
        end
        cyc(0, 4'hE, 0, 0, 0, 4'h0, 0, 1, 0, 0);
        chk("tbl_pend_err", 32'(pend_err), 32'd0);

        // Hazard stall, then bypass release (stale nzcv=1111 would squash NE)
        cyc(1, 4'hE, 1, 0, 0, 4'h0, 0, 1, 1, 1);
        cyc(1, 4'h1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'h1, 0, 0, 1, 4'b0000, 0, 1, 1, 1);
        chk("t3_pend", 32'(dut.pend_q), 32'd0);
        chk("t3_nzcv", 32'(nzcv), 32'd0);

        // Capacity: three writers in flight, fourth waits for a retire
        for (int i = 0; i < 3; i++) cyc(1, 4'hE, 1, 0, 0, 4'h0, 0, 1, 1, 1);
        chk("t4_pend3", 32'(dut.pend_q), 32'd3);
        cyc(1, 4'hE, 1, 0, 0, 4'h0, 0, 0, 0, 0);
        cyc(1, 4'hE, 1, 0, 1, 4'b0010, 0, 1, 1, 1);
        chk("t4_pend_hold", 32'(dut.pend_q), 32'd3);
        cyc(0, 4'hE, 0, 0, 1, 4'b0010, 0, 1, 0, 0);
        chk("t4_pend2", 32'(dut.pend_q), 32'd2);

        // Stall freezes the execute slot; flush overrides stall and clears pend
        cyc(1, 4'hE, 0, 0, 0, 4'h0, 0, 1, 1, 1);
        cyc(1, 4'hE, 0, 1, 0, 4'h0, 0, 0, 1, 1);
        cyc(1, 4'hE, 0, 1, 0, 4'h0, 0, 0, 1, 1);
        chk("t5_pend_stall", 32'(dut.pend_q), 32'd2);
        cyc(1, 4'hE, 0, 1, 0, 4'h0, 1, 0, 0, 0);
        chk("t5_pend_flush", 32'(dut.pend_q), 32'd0);
        chk("t5_squash", 32'(squash_cnt), 32'(exp_sq));

        // Underflow sticky error; failing S-op does not allocate
        cyc(0, 4'hE, 0, 0, 1, 4'b0100, 0, 1, 0, 0);
        chk("t6_pend_err", 32'(pend_err), 32'd1);
        chk("t6_nzcv", 32'(nzcv), 32'b0100);
        cyc(1, 4'hC, 1, 0, 0, 4'h0, 0, 1, 1, 0);
        exp_sq++;
        chk("t6_pend", 32'(dut.pend_q), 32'd0);
        chk("t6_squash", 32'(squash_cnt), 32'(exp_sq));
        cyc(0, 4'hE, 0, 0, 0, 4'h0, 0, 1, 0, 0);
        chk("t6_pend_err_sticky", 32'(pend_err), 32'd1);

        // Z set by writeback, then EQ/NE/NV
        cyc(0, 4'hE, 0, 0, 1, 4'b0100, 0, 1, 0, 0);
        cyc(1, 4'h0, 0, 0, 0, 4'h0, 0, 1, 1, 1);
        cyc(1, 4'h1, 0, 0, 0, 4'h0, 0, 1, 1, 0);
        cyc(1, 4'hF, 0, 0, 0, 4'h0, 0, 1, 1, 0);
        exp_sq += 2;
        chk("t2_squash", 32'(squash_cnt), 32'(exp_sq));

        // Writeback coincident with flush still lands in nzcv
        cyc(1, 4'hE, 0, 0, 1, 4'b1000, 1, 0, 0, 0);
        chk("flush_wb_nzcv", 32'(nzcv), 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
